// File: rtl/fp16_add_arbiter_if.sv
// Requester-side bundle of the shared fp16 adder arbiter: per-requester
// operation request/grant plus the shared response bus.
interface fp16_add_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*16-1:0] req_a;
  logic [NREQ*16-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [15:0]        rsp_data;

  // Requesters drive operands and consume grants/responses.
  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data
  );

  // Arbiter receives operands and returns grants/responses.
  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/fp16_add_arbiter.sv
// Round-robin arbiter sharing one external pipelined fp16 adder among NREQ
// requesters. One op is issued per cycle at most. The requester ID travels
// alongside the adder latency in a tag pipeline, so each sum is returned to
// the requester that issued it. Operand and result data are never inspected.
module fp16_add_arbiter #(
  parameter int NREQ        = 4,
  parameter int ADD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              hold,
  fp16_add_arbiter_if.slave bus,
  output logic [15:0]       add_a,
  output logic [15:0]       add_b,
  input  logic [15:0]       add_result,
  output logic              busy
);

  localparam int          IDW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREQ_U = NREQ;
  localparam int unsigned LAT_U  = ADD_LATENCY;

  logic                   gnt_vld;
  logic [IDW-1:0]         gnt_id;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [ADD_LATENCY-1:0] tag_vld_q;
  logic [IDW-1:0]         tag_id_q [ADD_LATENCY];

  // Round-robin search starting at the pointer; hold suppresses any grant.
  always_comb begin
    int unsigned idx;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NREQ_U; k++) begin
      idx = (32'(ptr_q) + k) % NREQ_U;
      if (!gnt_vld && bus.req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = IDW'(idx);
      end
    end
    if (hold) begin
      gnt_vld = 1'b0;
      gnt_id  = '0;
    end
  end

  // One-hot grant and operand mux; with no grant the adder sees 0+0.
  always_comb begin
    bus.req_ready = '0;
    add_a         = '0;
    add_b         = '0;
    if (gnt_vld) begin
      bus.req_ready[gnt_id] = 1'b1;
      add_a = bus.req_a[16*gnt_id +: 16];
      add_b = bus.req_b[16*gnt_id +: 16];
    end
  end

  // Pointer moves just past the granted requester; frozen without a transfer.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) begin
      ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Tag pipeline mirroring the adder latency; shifts every cycle, no stall.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      tag_vld_q <= '0;
      for (int unsigned s = 0; s < LAT_U; s++) begin
        tag_id_q[s] <= '0;
      end
    end else begin
      tag_vld_q[0] <= gnt_vld;
      tag_id_q[0]  <= gnt_id;
      for (int unsigned s = 1; s < LAT_U; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
    end
  end

  // Response steering from the last tag stage; result passes straight through.
  always_comb begin
    bus.rsp_valid = '0;
    if (tag_vld_q[ADD_LATENCY-1]) begin
      bus.rsp_valid[tag_id_q[ADD_LATENCY-1]] = 1'b1;
    end
  end

  assign bus.rsp_data = add_result;
  assign busy         = |tag_vld_q;

endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Directed bench for fp16_add_arbiter with NREQ=4, ADD_LATENCY=1. The adder is
// modelled as a one-register lookup of the operand pairs used by the vectors.
module tb_fp16_add_arbiter;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        hold = 1'b0;
  logic [15:0] add_a, add_b;
  logic [15:0] add_result = '0;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  fp16_add_arbiter_if #(.NREQ(4)) bus ();

  fp16_add_arbiter #(.NREQ(4), .ADD_LATENCY(1)) dut (
    .clk        (clk),
    .nRST       (nRST),
    .hold       (hold),
    .bus        (bus),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (add_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Stand-in adder: registers its operands once, returns known sums only.
  function automatic logic [15:0] fake_add(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      {16'h0000, 16'h0000}: return 16'h0000;
      {16'h3C00, 16'h3C00}: return 16'h4000;
      {16'h4000, 16'h3C00}: return 16'h4200;
      {16'h7C00, 16'hFC00}: return 16'h7E00;
      default:              return 16'hBAD0;
    endcase
  endfunction

  always @(posedge clk) add_result <= fake_add(add_a, add_b);

  typedef struct {
    logic        hold;
    logic [3:0]  valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  exp_ready;
    logic [3:0]  exp_rsp;
    logic [15:0] exp_data;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic h, input logic [3:0] v, input logic [15:0] a,
                              input logic [15:0] b, input logic [3:0] er, input logic [3:0] ersp,
                              input logic [15:0] ed, input logic eb);
    vec_t r;
    r.hold = h; r.valid = v; r.a = a; r.b = b;
    r.exp_ready = er; r.exp_rsp = ersp; r.exp_data = ed; r.exp_busy = eb;
    return r;
  endfunction

  // Valid lanes carry the real operand, idle lanes carry junk the mux must not pick.
  function automatic logic [63:0] lanes(input logic [3:0] v, input logic [15:0] x,
                                        input logic [15:0] junk);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[16*i +: 16] = v[i] ? x : junk;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic h, input logic [3:0] v, input logic [15:0] a, input logic [15:0] b);
    hold          = h;
    bus.req_valid = v;
    bus.req_a     = lanes(v, a, 16'h1111);
    bus.req_b     = lanes(v, b, 16'h2222);
  endtask

  initial begin
    drive(1'b0, 4'b0000, 16'h0, 16'h0);

    // Fairness from pointer 0 with all requesters active.
    vecs.push_back(mk(0, 4'hF, 16'h4000, 16'h3C00, 4'b0001, 4'b0000, 16'h0000, 0));
    vecs.push_back(mk(0, 4'hF, 16'h4000, 16'h3C00, 4'b0010, 4'b0001, 16'h4200, 1));
    vecs.push_back(mk(0, 4'hF, 16'h4000, 16'h3C00, 4'b0100, 4'b0010, 16'h4200, 1));
    vecs.push_back(mk(0, 4'hF, 16'h4000, 16'h3C00, 4'b1000, 4'b0100, 16'h4200, 1));
    vecs.push_back(mk(0, 4'hF, 16'h4000, 16'h3C00, 4'b0001, 4'b1000, 16'h4200, 1));
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 4'b0000, 4'b0001, 16'h4200, 1));
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 0));
    // Pointer at 1, only requesters 0 and 3: grants 3, 0, 3.
    vecs.push_back(mk(0, 4'h9, 16'h3C00, 16'h3C00, 4'b1000, 4'b0000, 16'h0000, 0));
    vecs.push_back(mk(0, 4'h9, 16'h3C00, 16'h3C00, 4'b0001, 4'b1000, 16'h4000, 1));
    vecs.push_back(mk(0, 4'h9, 16'h3C00, 16'h3C00, 4'b1000, 4'b0001, 16'h4000, 1));
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 4'b0000, 4'b1000, 16'h4000, 1));
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 0));
    // Single op on requester 2, pointer 0 -> 3.
    vecs.push_back(mk(0, 4'h4, 16'h3C00, 16'h3C00, 4'b0100, 4'b0000, 16'h0000, 0));
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 4'b0000, 4'b0100, 16'h4000, 1));
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 0));
    // Two ops, hold for 3 cycles, resume at saved pointer 1.
    vecs.push_back(mk(0, 4'hF, 16'h4000, 16'h3C00, 4'b1000, 4'b0000, 16'h0000, 0));
    vecs.push_back(mk(0, 4'hF, 16'h4000, 16'h3C00, 4'b0001, 4'b1000, 16'h4200, 1));
    vecs.push_back(mk(1, 4'hF, 16'h4000, 16'h3C00, 4'b0000, 4'b0001, 16'h4200, 1));
    vecs.push_back(mk(1, 4'hF, 16'h4000, 16'h3C00, 4'b0000, 4'b0000, 16'h0000, 0));
    vecs.push_back(mk(1, 4'hF, 16'h4000, 16'h3C00, 4'b0000, 4'b0000, 16'h0000, 0));
    vecs.push_back(mk(0, 4'hF, 16'h4000, 16'h3C00, 4'b0010, 4'b0000, 16'h0000, 0));
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 4'b0000, 4'b0010, 16'h4200, 1));
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 0));
    // Inf + -Inf passes through to requester 1 (pointer 2 wraps to 1).
    vecs.push_back(mk(0, 4'h2, 16'h7C00, 16'hFC00, 4'b0010, 4'b0000, 16'h0000, 0));
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 4'b0000, 4'b0010, 16'h7E00, 1));
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 0));
    // Sole requester is granted back-to-back.
    vecs.push_back(mk(0, 4'h4, 16'h3C00, 16'h3C00, 4'b0100, 4'b0000, 16'h0000, 0));
    vecs.push_back(mk(0, 4'h4, 16'h3C00, 16'h3C00, 4'b0100, 4'b0100, 16'h4000, 1));
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 4'b0000, 4'b0100, 16'h4000, 1));
    vecs.push_back(mk(0, 4'h0, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 0));

    // Reset state.
    repeat (2) @(posedge clk);
    #1 nRST = 1'b1;
    @(negedge clk);
    chk("reset ready", 64'(bus.req_ready), 64'h0);
    chk("reset rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("reset busy", 64'(busy), 64'h0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1 drive(vecs[i].hold, vecs[i].valid, vecs[i].a, vecs[i].b);
      @(negedge clk);
      chk($sformatf("row%0d ready", i), 64'(bus.req_ready), 64'(vecs[i].exp_ready));
      chk($sformatf("row%0d rsp_valid", i), 64'(bus.rsp_valid), 64'(vecs[i].exp_rsp));
      chk($sformatf("row%0d busy", i), 64'(busy), 64'(vecs[i].exp_busy));
      chk($sformatf("row%0d add_a", i), 64'(add_a),
          (vecs[i].exp_ready != 4'b0) ? 64'(vecs[i].a) : 64'h0);
      chk($sformatf("row%0d add_b", i), 64'(add_b),
          (vecs[i].exp_ready != 4'b0) ? 64'(vecs[i].b) : 64'h0);
      if (vecs[i].exp_rsp != 4'b0)
        chk($sformatf("row%0d rsp_data", i), 64'(bus.rsp_data), 64'(vecs[i].exp_data));
    end

    // Request raised under hold then dropped: nothing recorded. Pointer stays 3.
    @(posedge clk);
    #1 drive(1'b1, 4'b0010, 16'h3C00, 16'h3C00);
    @(negedge clk);
    chk("drop ready", 64'(bus.req_ready), 64'h0);
    @(posedge clk);
    #1 drive(1'b0, 4'b0000, 16'h0, 16'h0);
    @(negedge clk);
    chk("drop rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("drop busy", 64'(busy), 64'h0);

    // Async reset with an op in flight discards it and clears the pointer.
    @(posedge clk);
    #1 drive(1'b0, 4'hF, 16'h4000, 16'h3C00);
    @(negedge clk);
    chk("rst pre ready", 64'(bus.req_ready), 64'b1000);
    @(posedge clk);
    #1 drive(1'b0, 4'h0, 16'h0, 16'h0);
    @(negedge clk);
    chk("rst inflight rsp_valid", 64'(bus.rsp_valid), 64'b1000);
    chk("rst inflight busy", 64'(busy), 64'h1);
    #1 nRST = 1'b0;
    #1;
    chk("rst async rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("rst async busy", 64'(busy), 64'h0);
    @(posedge clk);
    #1 nRST = 1'b1;
    drive(1'b0, 4'hF, 16'h4000, 16'h3C00);
    @(negedge clk);
    chk("rst post ready", 64'(bus.req_ready), 64'b0001);
    chk("rst post add_a", 64'(add_a), 64'h4000);
    @(posedge clk);
    #1 drive(1'b0, 4'h0, 16'h0, 16'h0);
    @(negedge clk);
    chk("rst post rsp_valid", 64'(bus.rsp_valid), 64'b0001);
    chk("rst post rsp_data", 64'(bus.rsp_data), 64'h4200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
